// File: rtl/jts16b_busarb.sv
// 68000 bus-master arbiter for the S16B on-board DMA/MCU devices.
// Round-robin grant over BRn/BGn/BGACKn with tenure limit and CPU gap.
module jts16b_busarb #(
  parameter int N    = 2,
  parameter int TOUT = 255,
  parameter int GAP  = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cen,
  input  logic [N-1:0] dev_req,
  output logic [N-1:0] dev_gnt,
  output logic         cpu_brn,
  input  logic         cpu_bgn,
  output logic         cpu_bgackn,
  input  logic         cpu_asn,
  input  logic         cpu_dtackn,
  output logic [2:0]   owner,
  output logic         busy,
  output logic         tout_err
);

  localparam logic [7:0] TOUT_C = 8'(TOUT);
  localparam logic [2:0] GAP_C  = 3'(GAP);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAITBUS, S_OWN, S_REL, S_GAP
  } state_t;

  state_t      state_q;
  logic [N-1:0] gnt_q;
  logic        brn_q;
  logic        bgackn_q;
  logic [2:0]  owner_q;
  logic        busy_q;
  logic        tout_q;
  logic [7:0]  tcnt_q;
  logic [7:0]  tcnt_d;
  logic [2:0]  gap_q;
  logic [2:0]  gap_d;

  logic [2:0]   win;
  logic [N-1:0] win_oh;
  logic         hit;

  // first requester after the last owner, wrapping around
  always_comb begin
    win    = owner_q;
    win_oh = '0;
    hit    = 1'b0;
    for (int k = 1; k <= N; k++) begin
      for (int j = 0; j < N; j++) begin
        if (!hit && dev_req[j] && j == (int'(owner_q) + k) % N) begin
          win       = 3'(j);
          win_oh[j] = 1'b1;
          hit       = 1'b1;
        end
      end
    end
  end

  always_comb begin
    tcnt_d = (tcnt_q == TOUT_C) ? tcnt_q : tcnt_q + 8'd1;
    gap_d  = gap_q - 3'd1;
  end

  always_ff @(posedge clk) begin
    tout_q <= 1'b0;
    if (rst) begin
      state_q  <= S_IDLE;
      gnt_q    <= '0;
      brn_q    <= 1'b1;
      bgackn_q <= 1'b1;
      owner_q  <= 3'(N - 1);
      busy_q   <= 1'b0;
      tcnt_q   <= '0;
      gap_q    <= '0;
    end else if (cen) begin
      unique case (state_q)
        S_IDLE: begin
          if (|dev_req) begin
            state_q <= S_REQ;
            brn_q   <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        S_REQ: begin
          if (!cpu_bgn) begin
            state_q <= S_WAITBUS;
          end else if (!(|dev_req)) begin
            state_q <= S_IDLE;
            brn_q   <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        S_WAITBUS: begin
          if (cpu_asn && cpu_dtackn) begin
            brn_q <= 1'b1;
            if (hit) begin
              state_q  <= S_OWN;
              bgackn_q <= 1'b0;
              gnt_q    <= win_oh;
              owner_q  <= win;
              tcnt_q   <= '0;
            end else begin
              state_q <= S_GAP;
              gap_q   <= GAP_C;
            end
          end
        end
        S_OWN: begin
          tcnt_q <= tcnt_d;
          // a voluntary release wins over a coincident timeout
          if (!(|(dev_req & gnt_q))) begin
            state_q <= S_REL;
            gnt_q   <= '0;
          end else if (tcnt_d == TOUT_C) begin
            state_q <= S_REL;
            gnt_q   <= '0;
            tout_q  <= 1'b1;
          end
        end
        S_REL: begin
          state_q  <= S_GAP;
          bgackn_q <= 1'b1;
          gap_q    <= GAP_C;
        end
        S_GAP: begin
          gap_q <= gap_d;
          if (gap_d == 3'd0) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign dev_gnt    = gnt_q;
  assign cpu_brn    = brn_q;
  assign cpu_bgackn = bgackn_q;
  assign owner      = owner_q;
  assign busy       = busy_q;
  assign tout_err   = tout_q;

endmodule

// File: tb/tb_jts16b_busarb.sv
// Bench for jts16b_busarb: directed handshake scenarios plus random
// traffic, all checked against a phase-level model every clock.
module tb_jts16b_busarb;

  localparam int N    = 2;
  localparam int TOUT = 8;
  localparam int GAP  = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cen = 1'b1;
  logic [N-1:0] dev_req = '0;
  logic         cpu_bgn = 1'b1;
  logic         cpu_asn = 1'b1;
  logic         cpu_dtackn = 1'b1;
  logic [N-1:0] dev_gnt;
  logic         cpu_brn;
  logic         cpu_bgackn;
  logic [2:0]   owner;
  logic         busy;
  logic         tout_err;

  always #5 clk = ~clk;

  jts16b_busarb #(.N(N), .TOUT(TOUT), .GAP(GAP)) dut (
    .clk        (clk),
    .rst        (rst),
    .cen        (cen),
    .dev_req    (dev_req),
    .dev_gnt    (dev_gnt),
    .cpu_brn    (cpu_brn),
    .cpu_bgn    (cpu_bgn),
    .cpu_bgackn (cpu_bgackn),
    .cpu_asn    (cpu_asn),
    .cpu_dtackn (cpu_dtackn),
    .owner      (owner),
    .busy       (busy),
    .tout_err   (tout_err)
  );

  int total = 0;
  int bad   = 0;
  int n_tout = 0;
  bit chk_en = 0;
  bit cpu_auto = 0;
  bit cen_rand = 0;

  // phases: 0 idle, 1 asking CPU, 2 waiting bus, 3 device owns,
  // 4 releasing, 5 CPU recovery
  int ph = 0;
  int m_owner = N - 1;
  int held = 0;
  int gap_left = 0;
  bit m_tout = 0;

  function automatic int rr_pick(int last, logic [N-1:0] req);
    for (int k = 1; k <= N; k++)
      if (req[(last + k) % N]) return (last + k) % N;
    return last;
  endfunction

  always @(posedge clk) begin
    m_tout = 0;
    if (rst) begin
      ph = 0; m_owner = N - 1; held = 0; gap_left = 0;
    end else if (cen) begin
      case (ph)
        0: if (dev_req != 0) ph = 1;
        1: if (!cpu_bgn) ph = 2;
           else if (dev_req == 0) ph = 0;
        2: if (cpu_asn && cpu_dtackn) begin
             if (dev_req != 0) begin
               m_owner = rr_pick(m_owner, dev_req);
               held = 0; ph = 3;
             end else begin
               gap_left = GAP; ph = 5;
             end
           end
        3: begin
             held++;
             if (!dev_req[m_owner]) ph = 4;
             else if (held >= TOUT) begin ph = 4; m_tout = 1; end
           end
        4: begin gap_left = GAP; ph = 5; end
        5: begin gap_left--; if (gap_left == 0) ph = 0; end
        default: ph = 0;
      endcase
    end
  end

  logic [N-1:0] eg;
  logic e_brn, e_bgackn, e_busy;

  always @(negedge clk) begin
    if (chk_en) begin
      eg = (ph == 3) ? ({{(N-1){1'b0}}, 1'b1} << m_owner) : '0;
      e_brn    = !(ph == 1 || ph == 2);
      e_bgackn = !(ph == 3 || ph == 4);
      e_busy   = (ph != 0);
      total++;
      if ({dev_gnt, cpu_brn, cpu_bgackn, owner, busy, tout_err} !==
          {eg, e_brn, e_bgackn, 3'(m_owner), e_busy, m_tout}) begin
        bad++;
        $display("FAIL model t=%0t: gnt=%b brn=%b bgackn=%b own=%0d busy=%b tout=%b want gnt=%b brn=%b bgackn=%b own=%0d busy=%b tout=%b",
          $time, dev_gnt, cpu_brn, cpu_bgackn, owner, busy, tout_err,
          eg, e_brn, e_bgackn, m_owner, e_busy, m_tout);
      end
      total++;
      if ((dev_gnt != 0 && cpu_bgackn) || (!cpu_brn && !cpu_bgackn)) begin
        bad++;
        $display("FAIL invariant t=%0t: gnt=%b brn=%b bgackn=%b",
          $time, dev_gnt, cpu_brn, cpu_bgackn);
      end
      if (tout_err) n_tout++;
    end
  end

  always @(posedge clk) begin
    #1;
    if (cpu_auto && (!cen_rand || $urandom_range(0, 2) != 0))
      cpu_bgn = cpu_brn;
  end

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (cen_rand) cen = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_gnt(string nm);
    int i;
    i = 0;
    @(negedge clk);
    while (dev_gnt == 0 && i < 80) begin i++; @(negedge clk); end
    total++;
    if (dev_gnt == 0) begin
      bad++;
      $display("FAIL %s: no grant within %0d cycles", nm, i);
    end
  endtask

  task automatic wait_idle(string nm);
    int i;
    i = 0;
    @(negedge clk);
    while (busy && i < 80) begin i++; @(negedge clk); end
    total++;
    if (busy) begin
      bad++;
      $display("FAIL %s: still busy after %0d cycles", nm, i);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, k, i, base, b;
    @(posedge clk);
    chk_en = 1;
    @(posedge clk);
    @(negedge clk);
    chk("reset brn", cpu_brn, 1);
    chk("reset bgackn", cpu_bgackn, 1);
    chk("reset gnt", dev_gnt, 0);
    chk("reset owner", owner, N - 1);
    chk("reset busy", busy, 0);
    rst = 0;

    // single device, CPU late to grant and mid-cycle
    dev_req = 2'b01;
    repeat (3) step();
    @(negedge clk);
    chk("req brn", cpu_brn, 0);
    chk("req gnt", dev_gnt, 0);
    chk("req busy", busy, 1);
    cpu_bgn = 0; cpu_asn = 0;
    repeat (5) step();
    @(negedge clk);
    chk("midcycle bgackn", cpu_bgackn, 1);
    chk("midcycle gnt", dev_gnt, 0);
    cpu_asn = 1;
    step();
    @(negedge clk);
    chk("own bgackn", cpu_bgackn, 0);
    chk("own gnt", dev_gnt, 1);
    chk("own owner", owner, 0);
    chk("own brn", cpu_brn, 1);
    cpu_bgn = 1;
    repeat (3) step();
    dev_req = 2'b00;
    step();
    @(negedge clk);
    chk("rel gnt", dev_gnt, 0);
    chk("rel bgackn", cpu_bgackn, 0);
    step(); @(negedge clk);
    chk("gap bgackn", cpu_bgackn, 1);
    chk("gap busy", busy, 1);
    step(); @(negedge clk);
    chk("gap busy2", busy, 1);
    step(); @(negedge clk);
    chk("idle busy", busy, 0);

    // reset while a device owns the bus
    cpu_auto = 1;
    dev_req = 2'b01;
    wait_gnt("pre-reset grant");
    chk("pre-reset owner", owner, 0);
    rst = 1; dev_req = 2'b00;
    step();
    rst = 0;
    @(negedge clk);
    chk("rst-own brn", cpu_brn, 1);
    chk("rst-own bgackn", cpu_bgackn, 1);
    chk("rst-own gnt", dev_gnt, 0);
    chk("rst-own owner", owner, N - 1);
    chk("rst-own busy", busy, 0);
    chk("rst-own tout", tout_err, 0);

    // round robin with both devices requesting
    dev_req = 2'b11;
    for (int t = 0; t < 4; t++) begin
      wait_gnt("rr grant");
      chk("rr gnt", dev_gnt, (t % 2 == 0) ? 1 : 2);
      chk("rr owner", owner, t % 2);
      repeat (3) step();
      dev_req = (t % 2 == 0) ? 2'b10 : 2'b01;
      step();
      dev_req = 2'b11;
    end
    dev_req = 2'b00;
    wait_idle("rr idle");

    // timeout with a device that never lets go
    dev_req = 2'b01;
    base = n_tout;
    wait_gnt("tout grant");
    n = 0;
    while (dev_gnt != 0 && n < 300) begin n++; @(negedge clk); end
    chk("tout tenure", n, TOUT);
    i = 0;
    while (!cpu_bgackn && i < 20) begin i++; @(negedge clk); end
    k = 0;
    while (cpu_brn && k < 40) begin k++; @(negedge clk); end
    chk("tout cpu gap", k, GAP + 1);
    chk("tout pulses", n_tout - base, 1);
    dev_req = 2'b00;
    wait_idle("tout idle");

    // request withdrawn before the CPU grants
    cpu_auto = 0;
    cpu_bgn = 1;
    wait_idle("cancel pre");
    dev_req = 2'b01;
    step(); @(negedge clk);
    chk("cancel brn0", cpu_brn, 0);
    chk("cancel busy1", busy, 1);
    dev_req = 2'b00;
    step(); @(negedge clk);
    chk("cancel brn1", cpu_brn, 1);
    chk("cancel busy0", busy, 0);
    chk("cancel gnt", dev_gnt, 0);

    // random traffic, random cen, occasional reset
    cpu_auto = 1;
    cen_rand = 1;
    for (int r = 0; r < 4000; r++) begin
      step();
      if ($urandom_range(0, 7) == 0) begin
        b = $urandom_range(0, N - 1);
        dev_req[b] = ~dev_req[b];
      end
      cpu_asn = ($urandom_range(0, 3) != 0);
      cpu_dtackn = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 999) == 0);
    end
    cen_rand = 0;
    cen = 1;
    rst = 0;
    step();
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/jts16b_busarb.md
Name: jts16b_busarb

Overview:
- Arbitrates 68000 bus mastership among N on-board bus-master devices (MCU bus bridge, sprite/palette DMA, test DMA) through the BRn/BGn/BGACKn handshake.
- Sits between the S16B mapper's device request lines and the 68000 core.
- Grants at most one device at a time. Uses round-robin fairness, an ownership time limit and a guaranteed CPU recovery gap between tenures.

Parameters:
- N, 2, number of requesting devices (1..8).
- TOUT, 255, max CPU-cen cycles a device may own the bus before forced release (8-bit).
- GAP, 2, CPU-cen cycles the CPU keeps the bus after a release before BRn may reassert (1..7).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- cen  in  1  68000 clock enable; all FSM steps and counters advance only when cen=1.
- dev_req  in  N  per-device bus request, level, held until done.
- dev_gnt  out  N  one-hot grant; device may drive the bus while its bit is 1.
- cpu_brn  out  1  bus request to 68000, active low.
- cpu_bgn  in  1  bus grant from 68000, active low.
- cpu_bgackn  out  1  bus grant acknowledge, active low.
- cpu_asn  in  1  68000 address strobe.
- cpu_dtackn  in  1  current DTACKn seen by the CPU.
- owner  out  3  index of current/last granted device.
- busy  out  1  1 from BRn assertion until release completes.
- tout_err  out  1  one-clk pulse when a tenure is force-ended by TOUT.

Behaviour:
- Reset values: cpu_brn=1, cpu_bgackn=1, dev_gnt=0, owner=N-1 (so device 0 has first priority), busy=0, tout_err=0, state=IDLE, counters=0.
- Reset mid-operation has the same effect on the next clk edge, with no release sequencing. The 68000 is assumed to be reset alongside.
- States: IDLE, REQ, WAITBUS, OWN, REL, GAP. Transitions are evaluated on cen=1 clk edges only.
- IDLE:
  - If |dev_req, go to REQ and drive cpu_brn=0, busy=1.
- REQ:
  - Wait for cpu_bgn=0.
  - If all dev_req drop before the grant, drive cpu_brn=1, busy=0 and return to IDLE.
- WAITBUS (entered on bgn=0):
  - Wait until cpu_asn=1 and cpu_dtackn=1, which means the CPU's current cycle has ended.
  - Then select the winner, drive cpu_bgackn=0 and cpu_brn=1, set dev_gnt[winner]=1 and owner=winner, clear the tenure counter, and go to OWN.
  - If no request remains at this point, drive cpu_brn=1 and go to GAP without asserting bgack.
- Winner selection: round-robin. Search starts at owner+1 modulo N, first asserted dev_req wins. The winner is sampled once, in the WAITBUS→OWN transition only.
- OWN:
  - dev_gnt stays stable.
  - The tenure counter increments per cen, saturating at TOUT.
  - On dev_req[owner]=0, go to REL.
  - On counter==TOUT, go to REL and pulse tout_err for one clk.
  - Requests from other devices are ignored while in OWN.
- REL:
  - dev_gnt=0 immediately on entry.
  - Next cen: cpu_bgackn=1, load gap counter=GAP, go to GAP.
  - The device therefore sees gnt drop at least one cen before bgack releases.
- GAP:
  - Gap counter decrements per cen.
  - At 0, go to IDLE with busy=0. A pending request restarts REQ on the following cen, so the CPU gets at least GAP+1 cen cycles.
- Simultaneous events:
  - Release and timeout on the same cen: count as a release; no tout_err.
  - dev_req of the owner re-asserting in REL/GAP re-arbitrates normally; it does not extend the tenure.
- Invariants:
  - dev_gnt is never nonzero while cpu_bgackn=1.
  - cpu_brn and cpu_bgackn are never both 0 for more than the single transition edge.

Test Plan:
- Single device: dev_req=01, CPU grants after 3 cen -> brn low 3 cen, bgackn=0 and gnt=01 only after asn=1 & dtackn=1; drop req -> gnt=0, bgackn=1 one cen later, busy=0 after GAP cen.
- Round-robin: dev_req=11 held, each tenure lasts 4 cen then the owner drops and re-raises -> grants alternate 01,10,01,10 with owner 0,1,0,1.
- Timeout: TOUT=8, device holds req indefinitely -> gnt falls after 8 cen of OWN, tout_err one-clk pulse, CPU gets GAP+1 cen before brn reasserts.
- Cancelled request: req rises then falls while in REQ (bgn still 1) -> brn returns to 1, no gnt, state IDLE, busy=0.
- CPU mid-cycle: bgn=0 while asn=0 for 5 cen -> bgackn stays 1 until asn=1 & dtackn=1, then asserts on the next cen.
- Reset in OWN: assert rst one clk -> next edge brn=1, bgackn=1, gnt=0, owner=N-1, no tout_err.
